// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the core datapath (requester 0)
// and the auxiliary engine (requester 1). One transaction in flight: IDLE -> EXEC -> RESP.
module alu_arbiter #(
    parameter int unsigned W          = 8,
    parameter int unsigned Ops        = 4,
    parameter bit          PRIO_FIXED = 1'b0
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [Ops-1:0] req0_op,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [W-1:0]   rsp0_out,
    output logic           rsp0_flag,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [Ops-1:0] req1_op,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [W-1:0]   rsp1_out,
    output logic           rsp1_flag,

    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [Ops-1:0] alu_op,
    input  logic [W-1:0]   alu_out,
    input  logic           alu_flag,

    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [Ops-1:0] op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
    } req_t;

    state_t state;
    state_t next_state;
    req_t   opnd;
    req_t   sel_req;
    logic   owner;
    logic   last_owner;
    logic   grant0;
    logic   grant1;
    logic   accept;
    logic   capture;
    logic   retire;

    // A lone request wins; a tie goes to requester 0 (fixed) or away from last_owner.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (PRIO_FIXED || last_owner) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign sel_req = grant1 ? {req1_op, req1_a, req1_b} : {req0_op, req0_a, req0_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Ready is only offered in IDLE, so a held response blocks new requests.
    always_comb begin
        next_state = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    accept     = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                if (owner ? rsp1_ready : rsp0_ready) begin
                    retire     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand registers double as the ALU drive and are only non-zero during EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd       <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp0_out   <= '0;
            rsp0_flag  <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_out   <= '0;
            rsp1_flag  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            if (accept) begin
                opnd       <= sel_req;
                owner      <= grant1;
                last_owner <= grant1;
            end
            if (capture) begin
                opnd <= '0;
                if (owner) begin
                    rsp1_out   <= alu_out;
                    rsp1_flag  <= alu_flag;
                    rsp1_valid <= 1'b1;
                end else begin
                    rsp0_out   <= alu_out;
                    rsp0_flag  <= alu_flag;
                    rsp0_valid <= 1'b1;
                end
            end
            if (retire) begin
                rsp0_valid <= 1'b0;
                rsp1_valid <= 1'b0;
            end
        end
    end

    assign alu_a  = opnd.a;
    assign alu_b  = opnd.b;
    assign alu_op = opnd.op;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives a round-robin (index 0) and a fixed-priority (index 1) arbiter,
// each with a behavioural ALU, against a transaction-level reference model.
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_BEQ = 4'h6;
    localparam logic [3:0] OP_BNE = 4'h7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       v0 [2], v1 [2], rr0 [2], rr1 [2];
    logic       rdy0 [2], rdy1 [2], rv0 [2], rv1 [2], f0 [2], f1 [2], bsy [2], af [2];
    logic [3:0] op0 [2], op1 [2], aop [2];
    logic [7:0] a0 [2], b0 [2], a1 [2], b1 [2], o0 [2], o1 [2], aa [2], ab [2], ao [2];

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural ALU: {BranchFlag, Out}
    function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return {1'b0, a + b};
            OP_SUB:  return {1'b0, a - b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_BEQ:  return {a == b, a - b};
            OP_BNE:  return {a != b, a - b};
            default: return {1'b0, a};
        endcase
    endfunction

    assign {af[0], ao[0]} = alu_fn(aop[0], aa[0], ab[0]);
    assign {af[1], ao[1]} = alu_fn(aop[1], aa[1], ab[1]);

    alu_arbiter #(.W(8), .Ops(4), .PRIO_FIXED(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .req0_valid(v0[0]), .req0_ready(rdy0[0]), .req0_op(op0[0]), .req0_a(a0[0]), .req0_b(b0[0]),
        .rsp0_valid(rv0[0]), .rsp0_ready(rr0[0]), .rsp0_out(o0[0]), .rsp0_flag(f0[0]),
        .req1_valid(v1[0]), .req1_ready(rdy1[0]), .req1_op(op1[0]), .req1_a(a1[0]), .req1_b(b1[0]),
        .rsp1_valid(rv1[0]), .rsp1_ready(rr1[0]), .rsp1_out(o1[0]), .rsp1_flag(f1[0]),
        .alu_a(aa[0]), .alu_b(ab[0]), .alu_op(aop[0]), .alu_out(ao[0]), .alu_flag(af[0]),
        .busy(bsy[0])
    );

    alu_arbiter #(.W(8), .Ops(4), .PRIO_FIXED(1'b1)) u_fx (
        .clk(clk), .rst(rst),
        .req0_valid(v0[1]), .req0_ready(rdy0[1]), .req0_op(op0[1]), .req0_a(a0[1]), .req0_b(b0[1]),
        .rsp0_valid(rv0[1]), .rsp0_ready(rr0[1]), .rsp0_out(o0[1]), .rsp0_flag(f0[1]),
        .req1_valid(v1[1]), .req1_ready(rdy1[1]), .req1_op(op1[1]), .req1_a(a1[1]), .req1_b(b1[1]),
        .rsp1_valid(rv1[1]), .rsp1_ready(rr1[1]), .rsp1_out(o1[1]), .rsp1_flag(f1[1]),
        .alu_a(aa[1]), .alu_b(ab[1]), .alu_op(aop[1]), .alu_out(ao[1]), .alu_flag(af[1]),
        .busy(bsy[1])
    );

    // Requester obligation: a pending request keeps its payload until accepted or withdrawn.
    for (genvar g = 0; g < 2; g++) begin : g_obl
        a_hold0: assert property (@(posedge clk) disable iff (rst)
            (v0[g] && !rdy0[g]) |=> (!v0[g] || $stable({op0[g], a0[g], b0[g]})));
        a_hold1: assert property (@(posedge clk) disable iff (rst)
            (v1[g] && !rdy1[g]) |=> (!v1[g] || $stable({op1[g], a1[g], b1[g]})));
    end

    // Reference model: at most one in-flight transaction per arbiter.
    bit         m_busy [2];
    int         m_age [2];
    bit         m_own [2];
    bit         m_last [2];
    logic [3:0] m_op [2];
    logic [7:0] m_a [2], m_b [2];
    logic [7:0] m_out [2][2];
    logic       m_flag [2][2];
    bit         acc0 [2], acc1 [2];
    int         busy_cnt [2];
    int         dut_order [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        m_busy[d] = 1'b0;
        m_age[d]  = 0;
        m_own[d]  = 1'b0;
        m_last[d] = 1'b1;
        acc0[d]   = 1'b0;
        acc1[d]   = 1'b0;
        for (int r = 0; r < 2; r++) begin
            m_out[d][r]  = 8'h00;
            m_flag[d][r] = 1'b0;
        end
    endtask

    // Winner among current valids: {grant1, grant0}
    function automatic logic [1:0] exp_grant(input int d);
        int w;
        if (v0[d] && v1[d]) begin
            w = (d == 1) ? 0 : (m_last[d] ? 0 : 1);
            return (w == 0) ? 2'b01 : 2'b10;
        end
        return {v1[d], v0[d]};
    endfunction

    task automatic check_all(input int d);
        logic [1:0] g;
        bit         show;
        bit         exec;
        g    = m_busy[d] ? 2'b00 : exp_grant(d);
        show = m_busy[d] && (m_age[d] >= 1);
        exec = m_busy[d] && (m_age[d] == 0);
        check($sformatf("d%0d_req0_ready", d), 32'(rdy0[d]), 32'(g[0]));
        check($sformatf("d%0d_req1_ready", d), 32'(rdy1[d]), 32'(g[1]));
        check($sformatf("d%0d_busy", d), 32'(bsy[d]), 32'(m_busy[d]));
        check($sformatf("d%0d_rsp0_valid", d), 32'(rv0[d]), 32'(show && !m_own[d]));
        check($sformatf("d%0d_rsp1_valid", d), 32'(rv1[d]), 32'(show && m_own[d]));
        check($sformatf("d%0d_rsp0_out", d), 32'(o0[d]), 32'(m_out[d][0]));
        check($sformatf("d%0d_rsp0_flag", d), 32'(f0[d]), 32'(m_flag[d][0]));
        check($sformatf("d%0d_rsp1_out", d), 32'(o1[d]), 32'(m_out[d][1]));
        check($sformatf("d%0d_rsp1_flag", d), 32'(f1[d]), 32'(m_flag[d][1]));
        check($sformatf("d%0d_alu_op", d), 32'(aop[d]), exec ? 32'(m_op[d]) : 32'h0);
        check($sformatf("d%0d_alu_a", d), 32'(aa[d]), exec ? 32'(m_a[d]) : 32'h0);
        check($sformatf("d%0d_alu_b", d), 32'(ab[d]), exec ? 32'(m_b[d]) : 32'h0);
        if (bsy[d]) busy_cnt[d]++;
        if (d == 0 && rdy0[0] && v0[0]) dut_order.push_back(0);
        if (d == 0 && rdy1[0] && v1[0]) dut_order.push_back(1);
    endtask

    task automatic update(input int d);
        logic [1:0] g;
        acc0[d] = 1'b0;
        acc1[d] = 1'b0;
        if (rst) begin
            model_reset(d);
            return;
        end
        if (m_busy[d]) begin
            if (m_age[d] == 0) begin
                m_age[d] = 1;
                {m_flag[d][m_own[d]], m_out[d][m_own[d]]} = alu_fn(m_op[d], m_a[d], m_b[d]);
            end else if (m_own[d] ? rr1[d] : rr0[d]) begin
                m_busy[d] = 1'b0;
            end
        end else begin
            g = exp_grant(d);
            if (g[0]) begin
                m_busy[d] = 1'b1; m_age[d] = 0; m_own[d] = 1'b0; m_last[d] = 1'b0;
                m_op[d] = op0[d]; m_a[d] = a0[d]; m_b[d] = b0[d];
                acc0[d] = 1'b1;
            end else if (g[1]) begin
                m_busy[d] = 1'b1; m_age[d] = 0; m_own[d] = 1'b1; m_last[d] = 1'b1;
                m_op[d] = op1[d]; m_a[d] = a1[d]; m_b[d] = b1[d];
                acc1[d] = 1'b1;
            end
        end
    endtask

    // One clock: compare at negedge, advance the model, return 1 time unit after posedge.
    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_all(d);
        for (int d = 0; d < 2; d++) update(d);
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int d, input int r, input logic v, input logic [3:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        if (r == 0) begin
            v0[d] = v; op0[d] = op; a0[d] = a; b0[d] = b;
        end else begin
            v1[d] = v; op1[d] = op; a1[d] = a; b1[d] = b;
        end
    endtask

    task automatic drive_rand(input int d, input int p_req, input int p_rr);
        if (!v0[d] || acc0[d])
            set_req(d, 0, $urandom_range(99) < p_req, 4'($urandom_range(15)), 8'($urandom), 8'($urandom));
        else if ($urandom_range(99) < 4)
            v0[d] = 1'b0;
        if (!v1[d] || acc1[d])
            set_req(d, 1, $urandom_range(99) < p_req, 4'($urandom_range(15)), 8'($urandom), 8'($urandom));
        else if ($urandom_range(99) < 4)
            v1[d] = 1'b0;
        rr0[d] = ($urandom_range(99) < p_rr);
        rr1[d] = ($urandom_range(99) < p_rr);
    endtask

    task automatic single(input int r, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eo, input logic ef, input string tag);
        set_req(0, r, 1'b1, op, a, b);
        if (r == 0) rr0[0] = 1'b1; else rr1[0] = 1'b1;
        busy_cnt[0] = 0;
        cycle();
        set_req(0, r, 1'b0, op, a, b);
        cycle();
        check({tag, "_valid"}, 32'((r == 0) ? rv0[0] : rv1[0]), 32'h1);
        check({tag, "_out"}, 32'((r == 0) ? o0[0] : o1[0]), 32'(eo));
        check({tag, "_flag"}, 32'((r == 0) ? f0[0] : f1[0]), 32'(ef));
        cycle();
        cycle();
        check({tag, "_busy_cycles"}, 32'(busy_cnt[0]), 32'd2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0_grants;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            set_req(d, 0, 1'b0, 4'h0, 8'h00, 8'h00);
            set_req(d, 1, 1'b0, 4'h0, 8'h00, 8'h00);
            rr0[d] = 1'b0;
            rr1[d] = 1'b0;
            busy_cnt[d] = 0;
            model_reset(d);
        end
        cycle();
        cycle();
        check("reset_busy", 32'(bsy[0]), 32'h0);
        check("reset_rsp0_out", 32'(o0[0]), 32'h0);
        rst = 1'b0;

        // Single transactions: ADD overflow into bit 7, BNE taken and not taken
        single(0, OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, "t1_add");
        single(1, OP_BNE, 8'h03, 8'h05, 8'hFE, 1'b1, "t3_bne_ne");
        single(1, OP_BNE, 8'h05, 8'h05, 8'h00, 1'b0, "t3_bne_eq");

        // Round-robin ties after reset alternate 0,1,0,1
        rst = 1'b1;
        for (int d = 0; d < 2; d++) model_reset(d);
        cycle();
        rst = 1'b0;
        dut_order.delete();
        set_req(0, 0, 1'b1, OP_ADD, 8'($urandom), 8'($urandom));
        set_req(0, 1, 1'b1, OP_XOR, 8'($urandom), 8'($urandom));
        rr0[0] = 1'b1;
        rr1[0] = 1'b1;
        for (int i = 0; i < 40 && dut_order.size() < 4; i++) begin
            cycle();
            if (acc0[0]) set_req(0, 0, 1'b1, OP_SUB, 8'($urandom), 8'($urandom));
            if (acc1[0]) set_req(0, 1, 1'b1, OP_BEQ, 8'($urandom), 8'($urandom));
        end
        set_req(0, 0, 1'b0, 4'h0, 8'h00, 8'h00);
        set_req(0, 1, 1'b0, 4'h0, 8'h00, 8'h00);
        check("t2_grant_count", 32'(dut_order.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_order%0d", i), (i < dut_order.size()) ? 32'(dut_order[i]) : 32'hFFFF_FFFF,
                  32'(i % 2));
        repeat (4) cycle();

        // Stalled response holds result and blocks the other requester
        set_req(0, 0, 1'b1, OP_ADD, 8'h10, 8'h20);
        rr0[0] = 1'b0;
        cycle();
        set_req(0, 0, 1'b0, OP_ADD, 8'h10, 8'h20);
        set_req(0, 1, 1'b1, OP_OR, 8'h0F, 8'hF0);
        rr1[0] = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            check("t4_rsp0_out_stable", 32'(o0[0]), 32'h30);
            check("t4_busy", 32'(bsy[0]), 32'h1);
            check("t4_req1_blocked", 32'(rdy1[0]), 32'h0);
            cycle();
        end
        rr0[0] = 1'b1;
        cycle();
        check("t4_req1_ready", 32'(rdy1[0]), 32'h1);
        cycle();
        set_req(0, 1, 1'b0, OP_OR, 8'h0F, 8'hF0);
        cycle();
        check("t4_rsp1_out", 32'(o1[0]), 32'hFF);
        cycle();
        cycle();

        // Asynchronous reset during EXEC drops the transaction
        set_req(0, 0, 1'b1, OP_SUB, 8'h09, 8'h04);
        rr0[0] = 1'b1;
        cycle();
        set_req(0, 0, 1'b0, OP_SUB, 8'h09, 8'h04);
        #2;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) model_reset(d);
        #1;
        check("t5_busy", 32'(bsy[0]), 32'h0);
        check("t5_rsp0_valid", 32'(rv0[0]), 32'h0);
        check("t5_rsp1_valid", 32'(rv1[0]), 32'h0);
        check("t5_alu_op", 32'(aop[0]), 32'h0);
        check("t5_alu_a", 32'(aa[0]), 32'h0);
        check("t5_rsp0_out", 32'(o0[0]), 32'h0);
        check("t5_rsp1_out", 32'(o1[0]), 32'h0);
        cycle();
        cycle();
        rst = 1'b0;
        check("t5_no_rsp", 32'(rv0[0] | rv1[0]), 32'h0);
        set_req(0, 0, 1'b1, OP_AND, 8'h3C, 8'h0F);
        set_req(0, 1, 1'b1, OP_XOR, 8'hAA, 8'h55);
        rr1[0] = 1'b1;
        #1;
        check("t5_tie_req0", 32'(rdy0[0]), 32'h1);
        check("t5_tie_req1", 32'(rdy1[0]), 32'h0);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (acc0[0]) v0[0] = 1'b0;
            if (acc1[0]) v1[0] = 1'b0;
        end

        // Fixed priority: requester 1 starves while requester 0 keeps asking
        r0_grants = 0;
        set_req(1, 0, 1'b1, OP_ADD, 8'($urandom), 8'($urandom));
        set_req(1, 1, 1'b1, OP_SUB, 8'($urandom), 8'($urandom));
        rr1[1] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rr0[1] = 1'($urandom_range(1));
            #1;
            check("t6_req1_starved", 32'(rdy1[1] && v0[1]), 32'h0);
            if (rdy0[1]) r0_grants++;
            cycle();
            if (acc0[1]) set_req(1, 0, 1'b1, 4'($urandom_range(15)), 8'($urandom), 8'($urandom));
        end
        check("t6_req0_progress", 32'(r0_grants >= 5), 32'h1);
        set_req(1, 0, 1'b0, 4'h0, 8'h00, 8'h00);
        set_req(1, 1, 1'b0, 4'h0, 8'h00, 8'h00);
        rr0[1] = 1'b1;
        repeat (5) cycle();

        // Randomised traffic on both arbiters
        for (int i = 0; i < 3000; i++) begin
            drive_rand(0, (i < 1500) ? 60 : 95, (i < 1500) ? 70 : 30);
            drive_rand(1, (i < 1500) ? 60 : 95, (i < 1500) ? 70 : 30);
            cycle();
        end
        for (int d = 0; d < 2; d++) begin
            set_req(d, 0, 1'b0, 4'h0, 8'h00, 8'h00);
            set_req(d, 1, 1'b0, 4'h0, 8'h00, 8'h00);
            rr0[d] = 1'b1;
            rr1[d] = 1'b1;
        end
        repeat (5) cycle();
        check("final_idle_rr", 32'(bsy[0]), 32'h0);
        check("final_idle_fx", 32'(bsy[1]), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
